// File: rtl/if_id_queue_pkg.sv
// Shared constants and entry layout for the IF->ID decoupling queue.
// Entry = {pc, instr, exc, bd}, 70 bits.
package if_id_queue_pkg;

    localparam logic [4:0]  EXCCODE_NONE = 5'd0;
    localparam logic [4:0]  EXCCODE_ADEL = 5'd4;
    localparam logic [31:0] NOP_WORD     = 32'h0000_0000;
    localparam logic [31:0] RESET_PC     = 32'h0000_3000;
    localparam logic [31:0] HANDLER_PC   = 32'h0000_4180;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
    } entry_t;

    // A faulting fetch must never present a real opcode to decode.
    function automatic entry_t make_entry(input logic [31:0] pc, input logic [31:0] instr,
                                          input logic [4:0] exc, input logic bd);
        entry_t e;
        e.pc    = pc;
        e.instr = (exc != EXCCODE_NONE) ? NOP_WORD : instr;
        e.exc   = exc;
        e.bd    = bd;
        return e;
    endfunction

endpackage

// File: rtl/fifo_mem_2r.sv
// DEPTH x WIDTH register array: one synchronous write port, one combinational read port.
// Deliberately unreset; validity is tracked by the owner's pointers.
module fifo_mem_2r #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 70,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// Circular FIFO between fetch and decode, with flush on exception/ERET redirect.
// in_ready depends only on registered occupancy; no bypass from in_* to out_*.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int  DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_instr,
    input  logic [4:0]       in_exc,
    input  logic             in_bd,
    output logic             in_ready,
    output logic             out_valid,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_instr,
    output logic [4:0]       out_exc,
    output logic             out_bd,
    input  logic             out_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   occ;
    logic             push, pop;
    entry_t           wr_ent, rd_ent;

    assign in_ready  = (occ != FULL);
    assign out_valid = (occ != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = occ;
    assign wr_ent    = make_entry(in_pc, in_instr, in_exc, in_bd);

    fifo_mem_2r #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t))
    ) u_mem (
        .clk   (clk),
        .we    (push & rst_n & ~req),
        .waddr (wr_ptr),
        .wdata (wr_ent),
        .raddr (rd_ptr),
        .rdata (rd_ent)
    );

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (req) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                2'b10: begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                    occ    <= occ + (PTR_W + 1)'(1);
                end
                2'b01: begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                    occ    <= occ - (PTR_W + 1)'(1);
                end
                default: ;
            endcase
        end
    end

    // Empty queue presents a NOP bubble to decode.
    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        out_exc   = '0;
        out_bd    = 1'b0;
        if (out_valid) begin
            out_pc    = rd_ent.pc;
            out_instr = rd_ent.instr;
            out_exc   = rd_ent.exc;
            out_bd    = rd_ent.bd;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// Bench for if_id_queue: directed vector table, wrap-around stream and random traffic,
// all checked every cycle against a queue-based scoreboard.
module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n, req, in_valid, in_bd, out_ready;
    logic [31:0]      in_pc, in_instr;
    logic [4:0]       in_exc;
    logic             in_ready, out_valid, out_bd;
    logic [31:0]      out_pc, out_instr;
    logic [4:0]       out_exc;
    logic [PTR_W:0]   count;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .in_exc    (in_exc),
        .in_bd     (in_bd),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .out_exc   (out_exc),
        .out_bd    (out_bd),
        .out_ready (out_ready),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  exc;
        logic        bd;
    } sb_t;

    // Inputs for one cycle plus the outputs expected during that cycle (pre-edge state).
    typedef struct {
        logic        rst_n, req, in_valid;
        logic [31:0] pc, instr;
        logic [4:0]  exc;
        logic        out_ready;
        logic        exp_valid, exp_ready;
        int          exp_count;
        logic [31:0] exp_pc, exp_instr;
        logic [4:0]  exp_exc;
    } vec_t;

    sb_t sb[$];
    int  checks = 0;
    int  failures = 0;
    int  popped = 0;
    int  popped_pcs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input vec_t v, input bit use_exp);
        sb_t e;
        bit  m_push, m_pop;
        rst_n     = v.rst_n;
        req       = v.req;
        in_valid  = v.in_valid;
        in_pc     = v.pc;
        in_instr  = v.instr;
        in_exc    = v.exc;
        in_bd     = v.pc[2];
        out_ready = v.out_ready;
        #1;
        chk("count", 32'(count), 32'(sb.size()));
        chk("in_ready", 32'(in_ready), 32'(sb.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (sb.size() != 0) begin
            chk("out_pc", out_pc, sb[0].pc);
            chk("out_instr", out_instr, sb[0].instr);
            chk("out_exc", 32'(out_exc), 32'(sb[0].exc));
            chk("out_bd", 32'(out_bd), 32'(sb[0].bd));
        end else begin
            chk("bubble", {out_pc[15:0], out_instr[9:0], out_exc, out_bd}, 32'h0);
        end
        chk("inv_cnt_le_depth", 32'(count <= DEPTH), 32'd1);
        chk("inv_ptr_diff", 32'(PTR_W'(dut.wr_ptr - dut.rd_ptr)), 32'(PTR_W'(count)));
        if (use_exp) begin
            chk("vec_valid", 32'(out_valid), 32'(v.exp_valid));
            chk("vec_ready", 32'(in_ready), 32'(v.exp_ready));
            chk("vec_count", 32'(count), 32'(v.exp_count));
            chk("vec_pc", out_pc, v.exp_pc);
            chk("vec_instr", out_instr, v.exp_instr);
            chk("vec_exc", 32'(out_exc), 32'(v.exp_exc));
        end
        m_push = v.in_valid && (sb.size() < DEPTH);
        m_pop  = (sb.size() != 0) && v.out_ready;
        if (!v.rst_n || v.req) begin
            sb.delete();
        end else begin
            if (m_pop) begin
                popped++;
                popped_pcs.push_back(int'(sb[0].pc));
                void'(sb.pop_front());
            end
            if (m_push) begin
                e.pc    = v.pc;
                e.instr = (v.exc != 5'd0) ? 32'h0 : v.instr;
                e.exc   = v.exc;
                e.bd    = v.pc[2];
                sb.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(logic rn, logic rq, logic iv, logic [31:0] pc, logic [31:0] ins,
                                logic [4:0] ex, logic ordy, logic ev, logic er, int ec,
                                logic [31:0] epc, logic [31:0] eins, logic [4:0] eex);
        vec_t v;
        v.rst_n = rn; v.req = rq; v.in_valid = iv; v.pc = pc; v.instr = ins; v.exc = ex;
        v.out_ready = ordy; v.exp_valid = ev; v.exp_ready = er; v.exp_count = ec;
        v.exp_pc = epc; v.exp_instr = eins; v.exp_exc = eex;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        vec_t v;
        int   nxt;
        bit   acc;
        int   c;

        //        rn  rq  iv  pc            instr         exc  ordy ev er cnt  exp_pc        exp_instr     exp_exc
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 0, 1, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(1, 0, 1, 32'h3000,     32'h24010005, 0, 1, 0, 1, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 1, 1, 1, 32'h3000,     32'h24010005, 0));
        tbl.push_back(mk(1, 0, 1, 32'h3000,     32'h1,        0, 0, 0, 1, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(1, 0, 1, 32'h3004,     32'h2,        0, 0, 1, 1, 1, 32'h3000,     32'h1,        0));
        tbl.push_back(mk(1, 0, 1, 32'h3008,     32'h3,        0, 0, 1, 0, 2, 32'h3000,     32'h1,        0));
        tbl.push_back(mk(1, 0, 1, 32'h3008,     32'h3,        0, 0, 1, 0, 2, 32'h3000,     32'h1,        0));
        tbl.push_back(mk(1, 0, 1, 32'h3008,     32'h3,        0, 0, 1, 0, 2, 32'h3000,     32'h1,        0));
        tbl.push_back(mk(1, 0, 1, 32'h3008,     32'h3,        0, 1, 1, 0, 2, 32'h3000,     32'h1,        0));
        tbl.push_back(mk(1, 0, 1, 32'h3008,     32'h3,        0, 1, 1, 1, 1, 32'h3004,     32'h2,        0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 1, 1, 1, 32'h3008,     32'h3,        0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0, 1, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(1, 0, 1, 32'h2ffc,     32'h8c010000, 4, 0, 0, 1, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 1, 1, 1, 32'h2ffc,     32'h0,        4));
        tbl.push_back(mk(1, 0, 1, 32'h300c,     32'h4,        0, 0, 1, 1, 1, 32'h2ffc,     32'h0,        4));
        tbl.push_back(mk(1, 1, 1, 32'h3010,     32'h5,        0, 0, 1, 0, 2, 32'h2ffc,     32'h0,        4));
        tbl.push_back(mk(1, 0, 1, 32'h4180,     32'h6,        0, 0, 0, 1, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 0, 1, 1, 1, 32'h4180,     32'h6,        0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 1, 1, 1, 32'h4180,     32'h6,        0));
        tbl.push_back(mk(1, 0, 1, 32'h3014,     32'h7,        0, 0, 0, 1, 0, 32'h0,        32'h0,        0));
        tbl.push_back(mk(0, 1, 1, 32'h3018,     32'h8,        0, 0, 1, 1, 1, 32'h3014,     32'h7,        0));
        tbl.push_back(mk(1, 0, 0, 32'h0,        32'h0,        0, 1, 0, 1, 0, 32'h0,        32'h0,        0));

        rst_n = 1'b0; req = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
        in_exc = '0; in_bd = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) step(tbl[i], 1'b1);

        // Fill-and-stall order: exactly 0x3000, 0x3004, 0x3008 after the single pass.
        chk("stall_order_n", 32'(popped_pcs.size() >= 4), 32'd1);
        if (popped_pcs.size() >= 4) begin
            chk("stall_order0", 32'(popped_pcs[1]), 32'h3000);
            chk("stall_order1", 32'(popped_pcs[2]), 32'h3004);
            chk("stall_order2", 32'(popped_pcs[3]), 32'h3008);
        end

        // Wrap-around stream with out_ready toggling 1,0,1,0.
        popped = 0;
        popped_pcs.delete();
        nxt = 0;
        for (c = 0; c < 200 && (nxt < 10 || sb.size() != 0); c++) begin
            v = mk(1, 0, nxt < 10, 32'h3000 + 32'(4 * nxt), 32'h1000_0000 + 32'(nxt), 0,
                   (c % 2) == 0, 0, 0, 0, 0, 0, 0);
            acc = (nxt < 10) && (sb.size() < DEPTH);
            step(v, 1'b0);
            if (acc) nxt++;
        end
        chk("wrap_timeout", 32'(c < 200), 32'd1);
        chk("wrap_popped", 32'(popped), 32'd10);
        for (int i = 0; i < 10 && i < popped_pcs.size(); i++)
            chk("wrap_order", 32'(popped_pcs[i]), 32'h3000 + 32'(4 * i));

        // Random traffic including occasional flush and fetch exceptions.
        for (int i = 0; i < 300; i++) begin
            v = mk(1, $urandom_range(0, 19) == 0, 1'($urandom), $urandom, $urandom,
                   ($urandom_range(0, 7) == 0) ? 5'd4 : 5'd0, 1'($urandom), 0, 0, 0, 0, 0, 0);
            step(v, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
